// File: rtl/game_state_ctrl.sv
// -----------------------------------------------------------------------------
// game_state_ctrl
// Top-level game flow controller: TITLE -> PLAYER_TURN -> DODGE -> (PLAYER_TURN
// or END) -> TITLE. Counts dodge rounds, times each round in frame ticks and
// flags a win once MAX_ROUNDS rounds have been survived. Buttons are
// edge-detected here, and a button held through reset release is ignored until
// it has been released once.
// -----------------------------------------------------------------------------
module game_state_ctrl #(
    parameter int unsigned DODGE_FRAMES = 300,  // frame ticks per dodge round (1..1023)
    parameter int unsigned MAX_ROUNDS   = 8     // rounds survived for a win (1..255)
) (
    input  logic       Pclk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       btn_select,
    input  logic       character_alive,
    output logic [1:0] state_game,
    output logic [9:0] frames_left,
    output logic [7:0] round_count,
    output logic       game_won,
    output logic       bullets_en
);

    // State encoding is visible on state_game, so it is fixed rather than one-hot.
    localparam logic [1:0] ST_TITLE  = 2'd0;
    localparam logic [1:0] ST_PLAYER = 2'd1;
    localparam logic [1:0] ST_DODGE  = 2'd2;
    localparam logic [1:0] ST_END    = 2'd3;

    localparam logic [9:0] DODGE_LOAD   = DODGE_FRAMES[9:0];
    localparam logic [7:0] MAX_ROUNDS_C = MAX_ROUNDS[7:0];

    // Saturating 8-bit increment used for the round counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = 8'hFF;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    // ------------------------------------------------------------------
    // Button edge detection
    // ------------------------------------------------------------------
    logic btn_start_d_r;
    logic btn_select_d_r;
    // Arm flags: a button only counts once it has been seen low after reset,
    // so a button held across reset release cannot fake a press.
    logic start_arm_r;
    logic select_arm_r;
    logic start_press_s;
    logic select_press_s;

    // Register previous button levels and track release-since-reset.
    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            btn_start_d_r  <= 1'b0;
            btn_select_d_r <= 1'b0;
            start_arm_r    <= 1'b0;
            select_arm_r   <= 1'b0;
        end else begin
            btn_start_d_r  <= btn_start;
            btn_select_d_r <= btn_select;
            start_arm_r    <= start_arm_r | ~btn_start;
            select_arm_r   <= select_arm_r | ~btn_select;
        end
    end

    // Single-cycle press strobes from rising edges of armed buttons.
    always_comb begin
        start_press_s  = btn_start  & ~btn_start_d_r  & start_arm_r;
        select_press_s = btn_select & ~btn_select_d_r & select_arm_r;
    end

    // ------------------------------------------------------------------
    // Dodge-round events
    // ------------------------------------------------------------------
    logic [1:0] state_r;
    logic [1:0] state_nxt_s;
    logic [9:0] frames_left_r;
    logic [9:0] frames_nxt_s;
    logic [7:0] round_count_r;
    logic [7:0] round_nxt_s;
    logic       game_won_r;
    logic       won_nxt_s;

    logic       death_s;       // player died this cycle while dodging
    logic       tick_dec_s;    // frame tick consumed by the round timer
    logic       round_done_s;  // timer reaching zero with the player alive
    logic [7:0] round_inc_s;   // round count after a completed round
    logic       win_s;         // completed round reaches the win target

    // Derive death, tick and round-completion events; death masks the tick.
    always_comb begin
        death_s      = (state_r == ST_DODGE) & ~character_alive;
        tick_dec_s   = (state_r == ST_DODGE) & character_alive & frame_tick
                       & (frames_left_r != 10'd0);
        round_done_s = tick_dec_s & (frames_left_r == 10'd1);
        round_inc_s  = sat_inc8(round_count_r);
        win_s        = (round_inc_s == MAX_ROUNDS_C);
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // Hold the game state; reset lands in TITLE.
    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_TITLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // Each state reacts only to the button or event it owns.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_TITLE: begin
                if (start_press_s) begin
                    state_nxt_s = ST_PLAYER;
                end else begin
                    state_nxt_s = ST_TITLE;
                end
            end
            ST_PLAYER: begin
                if (select_press_s) begin
                    state_nxt_s = ST_DODGE;
                end else begin
                    state_nxt_s = ST_PLAYER;
                end
            end
            ST_DODGE: begin
                if (death_s) begin
                    state_nxt_s = ST_END;
                end else if (round_done_s) begin
                    if (win_s) begin
                        state_nxt_s = ST_END;
                    end else begin
                        state_nxt_s = ST_PLAYER;
                    end
                end else begin
                    state_nxt_s = ST_DODGE;
                end
            end
            ST_END: begin
                if (start_press_s) begin
                    state_nxt_s = ST_TITLE;
                end else begin
                    state_nxt_s = ST_END;
                end
            end
            default: begin
                state_nxt_s = ST_TITLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output (datapath next-value) logic
    // ------------------------------------------------------------------
    // Compute next timer, round count and win flag alongside the transitions.
    always_comb begin
        frames_nxt_s = frames_left_r;
        round_nxt_s  = round_count_r;
        won_nxt_s    = game_won_r;
        case (state_r)
            ST_TITLE: begin
                if (start_press_s) begin
                    round_nxt_s = 8'd0;
                    won_nxt_s   = 1'b0;
                end else begin
                    round_nxt_s = round_count_r;
                    won_nxt_s   = game_won_r;
                end
            end
            ST_PLAYER: begin
                if (select_press_s) begin
                    frames_nxt_s = DODGE_LOAD;
                end else begin
                    frames_nxt_s = frames_left_r;
                end
            end
            ST_DODGE: begin
                if (death_s) begin
                    // Timer freezes and the round is not credited.
                    won_nxt_s = 1'b0;
                end else if (tick_dec_s) begin
                    frames_nxt_s = frames_left_r - 10'd1;
                    if (round_done_s) begin
                        round_nxt_s = round_inc_s;
                        won_nxt_s   = win_s;
                    end else begin
                        round_nxt_s = round_count_r;
                    end
                end else begin
                    frames_nxt_s = frames_left_r;
                end
            end
            ST_END: begin
                if (start_press_s) begin
                    frames_nxt_s = 10'd0;
                end else begin
                    frames_nxt_s = frames_left_r;
                end
            end
            default: begin
                frames_nxt_s = 10'd0;
                round_nxt_s  = 8'd0;
                won_nxt_s    = 1'b0;
            end
        endcase
    end

    // Register the timer, round counter and win flag.
    always_ff @(posedge Pclk or negedge rst_n) begin
        if (!rst_n) begin
            frames_left_r <= 10'd0;
            round_count_r <= 8'd0;
            game_won_r    <= 1'b0;
        end else begin
            frames_left_r <= frames_nxt_s;
            round_count_r <= round_nxt_s;
            game_won_r    <= won_nxt_s;
        end
    end

    // Drive outputs from registers; bullets_en decodes the registered state.
    always_comb begin
        state_game  = state_r;
        frames_left = frames_left_r;
        round_count = round_count_r;
        game_won    = game_won_r;
        bullets_en  = (state_r == ST_DODGE);
    end

endmodule
